// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  localparam int          FETCH_DEPTH = 2;
  localparam logic [1:0]  FETCH_FULL  = 2'(FETCH_DEPTH);
  localparam logic [31:0] PC_INC      = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry FIFO of fetched {pc, instr} pairs. Entry 0 is always the head,
// so the head is a plain register and never shows X.
module fetch_buffer
  import fetch_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         flush_i,
  input  fetch_entry_t push_entry_i,
  output logic [1:0]   count_o,
  output fetch_entry_t head_o
);

  fetch_entry_t [FETCH_DEPTH-1:0] ent_q, ent_d;
  logic [1:0] cnt_q, cnt_d;
  logic       wr_idx;

  // With a pop the slots shift down first, so the tail write lands one lower.
  assign wr_idx = pop_i ? cnt_q[1] : cnt_q[0];

  always_comb begin
    ent_d = ent_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      cnt_d = '0;
    end else begin
      if (pop_i) ent_d[0] = ent_q[1];
      if (push_i) ent_d[wr_idx] = push_entry_i;
      case ({push_i, pop_i})
        2'b10:   cnt_d = cnt_q + 2'd1;
        2'b01:   cnt_d = cnt_q - 2'd1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ent_q <= '0;
      cnt_q <= '0;
    end else begin
      ent_q <= ent_d;
      cnt_q <= cnt_d;
    end
  end

  assign count_o = cnt_q;
  assign head_o  = ent_q[0];

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, fetch enable and a 2-entry decoupling buffer.
// Optional FETCH_MISALIGN_CHECK_EN blocks fetch after a misaligned redirect.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int          IMEM_W   = 14,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  output logic [IMEM_W-1:0] imem_addr_o,
  input  logic [31:0]       imem_rdata_i,
  input  logic              redirect_i,
  input  logic [31:0]       redirect_pc_i,
  output logic              id_valid_o,
  input  logic              id_ready_i,
  output logic [31:0]       id_instr_o,
  output logic [31:0]       id_pc_o,
  output logic              fetch_misalign_o
);

  logic [31:0]  pc_q, pc_d;
  logic [1:0]   count;
  logic         pop, fetch_en, fetch_blk;
  fetch_entry_t push_entry, head;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic misalign_q;

  // Sticky until the next redirect, which re-evaluates the target alignment.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)         misalign_q <= 1'b0;
    else if (redirect_i) misalign_q <= |redirect_pc_i[1:0];
  end

  assign fetch_blk = misalign_q;
`else
  assign fetch_blk = 1'b0;
`endif

  assign fetch_misalign_o = fetch_blk;

  assign pop      = id_valid_o & id_ready_i;
  assign fetch_en = ~redirect_i & ~fetch_blk & ((count != FETCH_FULL) | pop);

  always_comb begin
    pc_d = pc_q;
    if (redirect_i)    pc_d = redirect_pc_i;
    else if (fetch_en) pc_d = pc_q + PC_INC;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) pc_q <= RESET_PC;
    else         pc_q <= pc_d;
  end

  assign push_entry.pc    = pc_q;
  assign push_entry.instr = imem_rdata_i;

  // A redirect flushes; pop and push are both suppressed by that flush.
  fetch_buffer u_buf (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .push_i       (fetch_en),
    .pop_i        (pop),
    .flush_i      (redirect_i),
    .push_entry_i (push_entry),
    .count_o      (count),
    .head_o       (head)
  );

  assign imem_addr_o = pc_q[IMEM_W-1:0];
  assign id_valid_o  = (count != 2'd0);
  assign id_instr_o  = head.instr;
  assign id_pc_o     = head.pc;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage; memory returns addr ^ 0xA5A5_0000.
module tb_fetch_stage;

  localparam int IMEM_W = 14;

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic [IMEM_W-1:0] imem_addr_o;
  logic [31:0]       imem_rdata_i;
  logic              redirect_i;
  logic [31:0]       redirect_pc_i;
  logic              id_valid_o;
  logic              id_ready_i;
  logic [31:0]       id_instr_o;
  logic [31:0]       id_pc_o;
  logic              fetch_misalign_o;

  int n_chk = 0;
  int n_err = 0;

  fetch_stage #(.IMEM_W(IMEM_W), .RESET_PC(32'h0)) u_dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .imem_addr_o      (imem_addr_o),
    .imem_rdata_i     (imem_rdata_i),
    .redirect_i       (redirect_i),
    .redirect_pc_i    (redirect_pc_i),
    .id_valid_o       (id_valid_o),
    .id_ready_i       (id_ready_i),
    .id_instr_o       (id_instr_o),
    .id_pc_o          (id_pc_o),
    .fetch_misalign_o (fetch_misalign_o)
  );

  assign imem_rdata_i = {{(32-IMEM_W){1'b0}}, imem_addr_o} ^ 32'hA5A5_0000;

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic reset_dut(input logic rdy);
    rst_ni     = 1'b0;
    id_ready_i = rdy;
    redirect_i = 1'b0;
    #2;
    rst_ni = 1'b1;
  endtask

  initial begin
    rst_ni        = 1'b0;
    id_ready_i    = 1'b1;
    redirect_i    = 1'b0;
    redirect_pc_i = 32'h0;
    #1;
    chk("rst_valid", 32'(id_valid_o), 32'd0);
    chk("rst_instr", id_instr_o, 32'h0);
    chk("rst_pc", id_pc_o, 32'h0);
    chk("rst_misalign", 32'(fetch_misalign_o), 32'd0);
    chk("rst_addr", 32'(imem_addr_o), 32'h0);
    #2 rst_ni = 1'b1;

    // streaming with decode always ready
    tick();
    chk("s_valid", 32'(id_valid_o), 32'd1);
    chk("s_pc0", id_pc_o, 32'h0);
    chk("s_instr0", id_instr_o, 32'hA5A5_0000);
    chk("s_addr", 32'(imem_addr_o), 32'h4);
    for (int i = 1; i < 4; i++) begin
      tick();
      chk("s_pc", id_pc_o, 32'(4 * i));
      chk("s_instr", id_instr_o, 32'(4 * i) ^ 32'hA5A5_0000);
    end

    // backpressure for 6 edges
    reset_dut(1'b0);
    repeat (6) tick();
    chk("bp_valid", 32'(id_valid_o), 32'd1);
    chk("bp_addr_hold", 32'(imem_addr_o), 32'h8);
    id_ready_i = 1'b1;
    chk("bp_pc0", id_pc_o, 32'h0);
    for (int i = 1; i < 4; i++) begin
      tick();
      chk("bp_pc", id_pc_o, 32'(4 * i));
      chk("bp_instr", id_instr_o, 32'(4 * i) ^ 32'hA5A5_0000);
    end

    // redirect while full with a pop requested
    reset_dut(1'b0);
    repeat (3) tick();
    id_ready_i    = 1'b1;
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h100;
    tick();
    redirect_i = 1'b0;
    chk("rd_flush_valid", 32'(id_valid_o), 32'd0);
    chk("rd_addr", 32'(imem_addr_o), 32'h100);
    tick();
    chk("rd_valid", 32'(id_valid_o), 32'd1);
    chk("rd_pc", id_pc_o, 32'h100);
    chk("rd_instr", id_instr_o, 32'hA5A5_0100);
    tick();
    chk("rd_pc_next", id_pc_o, 32'h104);

    // PC wrap and address truncation
    redirect_i    = 1'b1;
    redirect_pc_i = 32'hFFFF_FFFC;
    tick();
    redirect_i = 1'b0;
    chk("wr_valid", 32'(id_valid_o), 32'd0);
    chk("wr_addr_top", 32'(imem_addr_o), 32'h3FFC);
    tick();
    chk("wr_pc_top", id_pc_o, 32'hFFFF_FFFC);
    chk("wr_instr_top", id_instr_o, 32'hA5A5_3FFC);
    chk("wr_addr_zero", 32'(imem_addr_o), 32'h0);
    tick();
    chk("wr_pc_zero", id_pc_o, 32'h0);
    chk("wr_instr_zero", id_instr_o, 32'hA5A5_0000);
    chk("wr_addr_four", 32'(imem_addr_o), 32'h4);

    // asynchronous reset with two entries buffered
    id_ready_i = 1'b0;
    tick();
    chk("ar_addr_full", 32'(imem_addr_o), 32'h8);
    chk("ar_valid_pre", 32'(id_valid_o), 32'd1);
    rst_ni = 1'b0;
    #1;
    chk("ar_valid", 32'(id_valid_o), 32'd0);
    chk("ar_addr", 32'(imem_addr_o), 32'h0);
    chk("ar_pc", id_pc_o, 32'h0);
    #1 rst_ni = 1'b1;
    tick();
    chk("ar_restart_valid", 32'(id_valid_o), 32'd1);
    chk("ar_restart_pc", id_pc_o, 32'h0);
    chk("ar_restart_addr", 32'(imem_addr_o), 32'h4);

    // misaligned redirect target
    id_ready_i    = 1'b1;
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h102;
    tick();
    redirect_i = 1'b0;
    chk("ma_flush_valid", 32'(id_valid_o), 32'd0);
`ifdef FETCH_MISALIGN_CHECK_EN
    chk("ma_flag", 32'(fetch_misalign_o), 32'd1);
    repeat (3) tick();
    chk("ma_flag_sticky", 32'(fetch_misalign_o), 32'd1);
    chk("ma_valid_blocked", 32'(id_valid_o), 32'd0);
`else
    chk("ma_flag_off", 32'(fetch_misalign_o), 32'd0);
    tick();
    chk("ma_pc", id_pc_o, 32'h102);
    chk("ma_instr", id_instr_o, 32'hA5A5_0102);
    tick();
    chk("ma_pc_next", id_pc_o, 32'h106);
`endif
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h200;
    tick();
    redirect_i = 1'b0;
    chk("ma_clear", 32'(fetch_misalign_o), 32'd0);
    chk("ma_clear_valid", 32'(id_valid_o), 32'd0);
    tick();
    chk("ma_pc200_valid", 32'(id_valid_o), 32'd1);
    chk("ma_pc200", id_pc_o, 32'h200);
    chk("ma_instr200", id_instr_o, 32'hA5A5_0200);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage: owns the program counter and drives the combinational-read instruction memory address each cycle.
- Captures the returned word, together with its PC, into a 2-entry fetch buffer.
- Presents buffered entries to decode over a valid/ready handshake.
- Decouples decode stalls from fetch; flushes on branch/jump redirect from execute.

Parameters:
- IMEM_W, 14, instruction memory byte-address width; must match the memory instance.
- RESET_PC, 32'h0000_0000, PC loaded on reset.

Ports:
- clk_i  input  1  clock
- rst_ni  input  1  reset
- imem_addr_o  output  IMEM_W  byte address to instruction memory (pc_q[IMEM_W-1:0])
- imem_rdata_i  input  32  instruction word, combinational from imem_addr_o, same cycle
- redirect_i  input  1  branch/jump taken; flush and reload PC
- redirect_pc_i  input  32  redirect target
- id_valid_o  output  1  buffer head holds a valid instruction
- id_ready_i  input  1  decode accepts head this cycle
- id_instr_o  output  32  head instruction
- id_pc_o  output  32  head PC
- fetch_misalign_o  output  1  redirect target misaligned (see Optional Feature)

Interface:
- One clock, clk_i.
- Reset rst_ni is asynchronous and active-low.

Behaviour:
- Reset values (asynchronous, rst_ni low):
  - pc_q = RESET_PC, buffer count = 0.
  - id_valid_o = 0, id_instr_o = 0, id_pc_o = 0, fetch_misalign_o = 0.
  - imem_addr_o = RESET_PC[IMEM_W-1:0].
- Handshake and fetch enable:
  - pop = id_valid_o & id_ready_i.
  - fetch_en = ~redirect_i & (count < 2 | pop).
- On fetch_en (clock edge):
  - push {pc_q, imem_rdata_i} into the buffer tail.
  - pc_q <= pc_q + 32'd4, modulo 2^32 (0xFFFF_FFFC wraps to 0x0).
- On pop: head is removed; the next entry, if any, becomes head.
- Push and pop in the same cycle: count unchanged; ordering preserved (FIFO).
- Full buffer (count = 2) and no pop:
  - pc_q holds.
  - imem_addr_o holds, so the same word is refetched later with no loss.
- Redirect (redirect_i = 1) has priority over all else:
  - count <= 0, pop is ignored, and the word currently on imem_rdata_i is discarded.
  - pc_q <= redirect_pc_i.
  - Next cycle imem_addr_o = redirect_pc_i[IMEM_W-1:0].
  - The first new entry is valid 1 cycle after the redirect edge.
- Latency:
  - Instruction at pc_q is visible on id_* one edge after it is addressed.
  - After reset release: first edge pushes RESET_PC; id_valid_o goes high after that edge.
- id_instr_o and id_pc_o reflect the head entry; they are don't-care when id_valid_o = 0 but are driven from registers (no X).
- PC bits [1:0]: imem_addr_o carries them unchanged; the memory ignores them.
- Address truncation: PC bits above IMEM_W-1 are dropped on imem_addr_o (address aliasing); the full 32-bit PC travels with the entry.
- Reset asserted mid-operation: immediate return to reset values; buffer contents lost.

Optional Feature:
- Macro: FETCH_MISALIGN_CHECK_EN.
- Defined:
  - A redirect with redirect_pc_i[1:0] != 2'b00 sets a sticky misalign flag.
  - fetch_misalign_o = flag, cleared only by the next aligned redirect or by reset.
  - While the flag is set, fetch_en is forced 0; id_valid_o drains the existing buffer, which is empty after a flush.
- Undefined:
  - fetch_misalign_o tied 0.
  - The low bits of the target are passed through unchecked.

Decomposition:
- Package fetch_pkg:
  - typedef fetch_entry_t (packed struct: logic [31:0] pc, logic [31:0] instr).
  - localparam FETCH_DEPTH = 2, localparam PC_INC = 32'd4.
- Sub-module fetch_buffer:
  - 2-entry FIFO of fetch_entry_t.
  - Ports: push/pop/flush, count, head.
  - Asynchronous active-low reset, same clock.
- fetch_stage holds the PC register, the fetch_en logic and the optional check.

Test Plan:
- Reset, id_ready_i = 1, memory preloaded with word(addr) = addr ^ 0xA5A5_0000:
  - id_valid_o high after the first edge.
  - Consecutive pops yield pc 0x0, 0x4, 0x8, 0xC with the matching words.
- Backpressure, id_ready_i = 0 for 6 cycles after reset:
  - Count saturates at 2; imem_addr_o holds at 0x8.
  - On release, pops in order pc 0x0, 0x4, 0x8 with no duplicate or gap.
- Redirect to 0x100 while the buffer is full and id_ready_i = 1 in the same cycle:
  - Pop ignored, buffer flushed.
  - Next valid entry has pc 0x100; no stale 0x4/0x8 appears.
- Wrap: redirect to 0xFFFF_FFFC:
  - Entries pc 0xFFFF_FFFC then 0x0000_0000.
  - imem_addr_o = 0x3FFC then 0x0000.
- Reset asserted asynchronously mid-stream with 2 entries buffered:
  - id_valid_o falls without waiting for an edge.
  - After release, fetch restarts at RESET_PC.
- With FETCH_MISALIGN_CHECK_EN, redirect to 0x102:
  - fetch_misalign_o = 1 and stays; id_valid_o stays 0.
  - A subsequent redirect to 0x200 clears the flag; pc 0x200 is delivered next.
